// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the wide add sequencer.
//   state_t         : sequencer FSM state encoding
//   DEF_SLICE_BITS  : default width of the shared carry-lookahead adder
//   DEF_NUM_SLICES  : default number of slices per operation
//   cnt_width()     : width of the slice counter for a given slice count
package wide_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned DEF_SLICE_BITS = 16;
    localparam int unsigned DEF_NUM_SLICES = 4;

    // A single-slice build still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Requester <-> sequencer bundle.
//   start          : request, sampled by the sequencer only when idle
//   a_in, b_in     : operands, captured on the accepted start
//   Cin            : carry-in, captured on the accepted start
//   sub            : subtract select (only when WIDE_ADD_SUB_EN is defined)
//   sum, Cout      : registered result and carry-out
//   busy, done     : operation in flight / one-cycle result-valid pulse
// Modports: master = requester, slave = sequencer.
interface wide_add_sequencer_if
    import wide_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_SLICE_BITS * DEF_NUM_SLICES
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             Cin;
`ifdef WIDE_ADD_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             Cout;
    logic             busy;
    logic             done;

`ifdef WIDE_ADD_SUB_EN
    modport master (output start, a_in, b_in, Cin, sub, input sum, Cout, busy, done);
    modport slave  (input start, a_in, b_in, Cin, sub, output sum, Cout, busy, done);
`else
    modport master (output start, a_in, b_in, Cin, input sum, Cout, busy, done);
    modport slave  (input start, a_in, b_in, Cin, output sum, Cout, busy, done);
`endif

endinterface

// File: rtl/wide_add_sequencer_cla.sv
// Combinational Nbits-wide carry-lookahead adder shared by the sequencer.
//   a, b : operands        cin  : carry-in
//   sum  : a + b + cin     cout : carry-out of the top bit
module CarryLookAheadAdderContinuousAssigment #(
    parameter int unsigned Nbits = 16
) (
    input  logic [Nbits-1:0] a,
    input  logic [Nbits-1:0] b,
    input  logic             cin,
    output logic [Nbits-1:0] sum,
    output logic             cout
);

    logic [Nbits-1:0] g;
    logic [Nbits-1:0] p;
    logic [Nbits:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat function of g, p and cin: no carry feeds another.
    always_comb begin
        logic acc;
        logic prop;
        acc  = 1'b0;
        prop = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(Nbits); i++) begin
            acc  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = acc | (prop & cin);
        end
    end

    assign sum  = p ^ c[Nbits-1:0];
    assign cout = c[Nbits];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit adder built from one SLICE_BITS-wide CLA, one slice per
// clock, LSB slice first, carry chained through a register.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of wide_add_sequencer_if (start/operands in, result out)
// Optional: define WIDE_ADD_SUB_EN to add the sub input (result a_in - b_in,
// Cout=1 meaning no borrow).
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned SLICE_BITS = DEF_SLICE_BITS,
    parameter int unsigned NUM_SLICES = DEF_NUM_SLICES
) (
    input logic                clk,
    input logic                reset,
    wide_add_sequencer_if.slave bus
);

    localparam int unsigned     WIDTH      = SLICE_BITS * NUM_SLICES;
    localparam int unsigned     CW         = cnt_width(NUM_SLICES);
    localparam logic [CW-1:0]   LAST_SLICE = CW'(NUM_SLICES - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         slice_cnt_q;
    logic                  carry_q;
    logic [WIDTH-1:0]      a_q, b_q;
    logic [WIDTH-1:0]      partial_q, partial_d;
    logic [WIDTH-1:0]      sum_q;
    logic                  cout_q;
    logic [WIDTH-1:0]      b_cap;
    logic                  c_cap;
    logic [SLICE_BITS-1:0] cla_sum;
    logic                  cla_cout;

    CarryLookAheadAdderContinuousAssigment #(
        .Nbits (SLICE_BITS)
    ) u_cla (
        .a    (a_q[slice_cnt_q*SLICE_BITS +: SLICE_BITS]),
        .b    (b_q[slice_cnt_q*SLICE_BITS +: SLICE_BITS]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // Subtraction is a + ~b + 1, so only the captured b and carry differ.
    always_comb begin
`ifdef WIDE_ADD_SUB_EN
        b_cap = bus.sub ? ~bus.b_in : bus.b_in;
        c_cap = bus.sub ? 1'b1 : bus.Cin;
`else
        b_cap = bus.b_in;
        c_cap = bus.Cin;
`endif
    end

    // Partial result with the current slice merged in; on the last slice this
    // is the complete sum.
    always_comb begin
        partial_d = partial_q;
        partial_d[slice_cnt_q*SLICE_BITS +: SLICE_BITS] = cla_sum;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (slice_cnt_q == LAST_SLICE) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            slice_cnt_q <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            partial_q   <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q         <= bus.a_in;
                        b_q         <= b_cap;
                        carry_q     <= c_cap;
                        slice_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    partial_q   <= partial_d;
                    carry_q     <= cla_cout;
                    slice_cnt_q <= slice_cnt_q + 1'b1;
                    if (slice_cnt_q == LAST_SLICE) begin
                        sum_q  <= partial_d;
                        cout_q <= cla_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: a cycle-level timing/arithmetic
// model checked every cycle, plus directed vectors with literal expectations.
module tb_wide_add_sequencer;

    localparam int unsigned SB = 16;
    localparam int unsigned NS = 4;
    localparam int unsigned W  = SB * NS;

    logic clk = 1'b0;
    logic reset;

    wide_add_sequencer_if #(.WIDTH(W)) bus ();

    wide_add_sequencer #(
        .SLICE_BITS (SB),
        .NUM_SLICES (NS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: an accepted start opens a busy window of NS+1 cycles; done is the
    // last cycle of it and the result becomes visible in that same cycle.
    int         m_left;
    logic [W:0] m_pend;
    logic [W:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_pend <= '0;
            m_res  <= '0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left <= NS + 1;
`ifdef WIDE_ADD_SUB_EN
                if (bus.sub)
                    m_pend <= {1'b0, bus.a_in} + {1'b0, ~bus.b_in} + 1;
                else
`endif
                    m_pend <= {1'b0, bus.a_in} + {1'b0, bus.b_in} + (W+1)'(bus.Cin);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pend;
        end
    end

    always @(negedge clk) begin
        check("busy", (W+1)'(bus.busy), (W+1)'(m_left != 0));
        check("done", (W+1)'(bus.done), (W+1)'(m_left == 1));
        check("result", {bus.Cout, bus.sum}, m_res);
    end

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic sub_v);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.Cin   = cin;
`ifdef WIDE_ADD_SUB_EN
        bus.sub   = sub_v;
`else
        if (sub_v) $display("note: sub requested without WIDE_ADD_SUB_EN");
`endif
    endtask

    // One full operation with latency, busy-length and literal result checks.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub_v,
                          input logic [W-1:0] es, input logic ec);
        int lat;
        int busy_n;
        bit seen;
        lat = 0; busy_n = 0; seen = 1'b0;
        @(negedge clk);
        drive_start(a, b, cin, sub_v);
        @(negedge clk);
        // Operands change after the start edge and must not matter.
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        bus.Cin   = ~cin;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, " done seen"}, (W+1)'(seen), (W+1)'(1));
        check({tag, " latency"}, (W+1)'(lat), (W+1)'(NS + 1));
        check({tag, " busy cycles"}, (W+1)'(busy_n), (W+1)'(NS + 1));
        check({tag, " sum"}, {1'b0, bus.sum}, {1'b0, es});
        check({tag, " Cout"}, (W+1)'(bus.Cout), (W+1)'(ec));
    endtask

    initial begin
        int dn;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.Cin   = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        // Reset held with start asserted: everything stays cleared.
        drive_start(64'd10, 64'd20, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst sum", {1'b0, bus.sum}, '0);
        check("rst Cout", (W+1)'(bus.Cout), '0);
        check("rst busy", (W+1)'(bus.busy), '0);
        check("rst done", (W+1)'(bus.done), '0);
        reset = 1'b0;
        @(negedge clk);
        check("start after reset", (W+1)'(bus.busy), (W+1)'(1));
        bus.start = 1'b0;
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("post-reset done count", (W+1)'(dn), (W+1)'(1));
        check("post-reset sum", {1'b0, bus.sum}, (W+1)'(30));

        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1);
        run_op("chain", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0,
               64'h0001_0000_0001_0001, 1'b0);
        run_op("msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
               64'h0, 1'b1);
        run_op("mixed", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
               64'h1234_5678_9ABC_DF01, 1'b0);
        run_op("zero", 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);

        // Start pulsed mid-run is ignored; only one done pulse.
        @(negedge clk);
        drive_start(64'd3, 64'd4, 1'b0, 1'b0);
        dn = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
            case (k)
                1: begin bus.start = 1'b0; bus.a_in = 64'd55; end
                2: drive_start(64'd100, 64'd100, 1'b0, 1'b0);
                3: bus.start = 1'b0;
                default: ;
            endcase
        end
        check("ignore done count", (W+1)'(dn), (W+1)'(1));
        check("ignore sum", {bus.Cout, bus.sum}, (W+1)'(7));

        // Reset on the 2nd RUN cycle aborts the operation.
        @(negedge clk);
        drive_start(64'd1000, 64'd2000, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort done", (W+1)'(bus.done), '0);
        check("abort sum", {1'b0, bus.sum}, '0);
        check("abort Cout", (W+1)'(bus.Cout), '0);
        check("abort busy", (W+1)'(bus.busy), '0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort no done", (W+1)'(dn), '0);
        run_op("after abort", 64'd1000, 64'd2000, 1'b1, 1'b0, 64'd3001, 1'b0);

`ifdef WIDE_ADD_SUB_EN
        run_op("sub neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("sub pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

endmodule
